custom_axi_ip_mc: RTL

Multi-channel, parametrised successor to the single-channel register-driven processing IP.
- Accepts a command from the register block (channel, opcode, operand, step, iteration count).
- Runs an iterative add/increment/accumulate sequence and writes the result back with a one-cycle write-enable.
- Reports progress through the shared `status_e` enum.
- Keeps one persistent accumulator and one sticky overflow flag per channel, between the register file and the IP's software-visible status registers.

---
 rtl/custom_axi_ip_pkg.sv | 24 ++
 rtl/custom_axi_ip_mc_alu.sv | 23 ++
 rtl/custom_axi_ip_mc.sv | 133 +++++++++++++
 3 files changed

// File: rtl/custom_axi_ip_pkg.sv
// Shared types for the custom AXI IP family: FSM status encoding, opcodes and
// the channel-index width helper.
package custom_axi_ip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        OP_INC  = 2'd0,
        OP_ADD  = 2'd1,
        OP_ACC  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    // A single-channel build still needs a one-bit channel select.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/custom_axi_ip_mc_alu.sv
// Combinational adder returning sum and carry-out. With CUSTOM_AXI_IP_SAT_EN
// defined the sum clamps to all-ones on carry; otherwise it wraps.
module custom_axi_ip_mc_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  carry
);

    logic [DATA_WIDTH:0] full;

    assign full  = {1'b0, a} + {1'b0, b};
    assign carry = full[DATA_WIDTH];

`ifdef CUSTOM_AXI_IP_SAT_EN
    assign sum = full[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : full[DATA_WIDTH-1:0];
`else
    assign sum = full[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/custom_axi_ip_mc.sv
// Multi-channel iterative add/increment/accumulate engine with per-channel
// accumulators and sticky overflow flags. Saturation via CUSTOM_AXI_IP_SAT_EN.
module custom_axi_ip_mc
    import custom_axi_ip_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_CH     = 4,
    parameter int  ITER_W     = 8,
    localparam int CH_W       = ch_width(NUM_CH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [CH_W-1:0]       ch_sel_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] operand_i,
    input  logic [DATA_WIDTH-1:0] step_i,
    input  logic [ITER_W-1:0]     iter_i,
    input  logic [NUM_CH-1:0]     clr_ovf_i,
    output logic                  ready_o,
    output logic                  wen_o,
    output logic [CH_W-1:0]       ch_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output status_e               status_o,
    output logic [NUM_CH-1:0]     ovf_o
);

    // Handshake: a command is taken on a rising edge where start_i=1 and
    // ready_o=1; start_i at any other time is dropped, never queued.

    status_e               state_q, state_d;
    op_e                   op_in, op_q;
    logic [CH_W-1:0]       ch_q;
    logic [DATA_WIDTH-1:0] operand_q, step_q, work_q, result_q;
    logic [ITER_W-1:0]     cnt_q;
    logic [NUM_CH-1:0]     ovf_q, ovf_set;
    logic [DATA_WIDTH-1:0] acc_q [NUM_CH];

    logic                  ch_ok, cmd_err;
    logic [DATA_WIDTH-1:0] acc_rd, init_val, alu_b, alu_sum;
    logic                  alu_carry;

    assign op_in    = op_e'(op_i);
    assign ch_ok    = ({1'b0, ch_sel_i} < (CH_W+1)'(NUM_CH));
    assign cmd_err  = (op_in == OP_RSVD) || !ch_ok;
    assign acc_rd   = ch_ok ? acc_q[ch_sel_i] : '0;
    assign init_val = (op_in == OP_ACC) ? acc_rd : operand_i;

    always_comb begin
        alu_b = operand_q;
        case (op_q)
            OP_INC:  alu_b = DATA_WIDTH'(1);
            OP_ADD:  alu_b = step_q;
            default: alu_b = operand_q;
        endcase
    end

    custom_axi_ip_mc_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .a     (work_q),
        .b     (alu_b),
        .sum   (alu_sum),
        .carry (alu_carry)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (cmd_err)             state_d = ERROR;
                    else if (iter_i == '0)   state_d = DONE;
                    else                     state_d = BUSY;
                end
            end
            BUSY:    if (cnt_q == ITER_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ovf_set = '0;
        if (state_q == BUSY && alu_carry) ovf_set[ch_q] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q      <= OP_INC;
            ch_q      <= '0;
            operand_q <= '0;
            step_q    <= '0;
            work_q    <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= '0;
            for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
        end else begin
            // Set is ORed in after the clear so a same-edge carry wins.
            ovf_q <= (ovf_q & ~clr_ovf_i) | ovf_set;
            if (state_q == IDLE && start_i) begin
                op_q      <= op_in;
                ch_q      <= ch_sel_i;
                operand_q <= operand_i;
                step_q    <= step_i;
                cnt_q     <= iter_i;
                work_q    <= init_val;
                if (state_d == DONE) result_q <= init_val;
            end
            if (state_q == BUSY) begin
                work_q <= alu_sum;
                cnt_q  <= cnt_q - ITER_W'(1);
                if (cnt_q == ITER_W'(1)) begin
                    result_q <= alu_sum;
                    if (op_q == OP_ACC) acc_q[ch_q] <= alu_sum;
                end
            end
        end
    end

    assign ready_o  = (state_q == IDLE) && !rst_i;
    assign wen_o    = (state_q == DONE);
    assign ch_o     = ch_q;
    assign result_o = result_q;
    assign status_o = state_q;
    assign ovf_o    = ovf_q;

endmodule
